// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential multiplier and its display-side consumers.
package seq_mult_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ripple_adder_n.sv
// Parameterised WIDTH-bit ripple-carry adder (full-adder chain) with carry-out.
module ripple_adder_n #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  always_comb begin
    logic c;
    c   = 1'b0;
    sum = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum[i] = x[i] ^ y[i] ^ c;
      c      = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/seq_mult_ctrl.sv
// Shift-and-add unsigned WIDTH x WIDTH multiplier with start/busy/done handshake.
// Optional SEQ_MULT_ZERO_BYPASS_EN: zero operands skip RUN and finish next cycle.
module seq_mult_ctrl
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic             carry;

  assign addend = mplier[0] ? mcand : '0;

  ripple_adder_n #(.WIDTH(WIDTH)) u_adder (
    .x    (acc),
    .y    (addend),
    .sum  (sum),
    .cout (carry)
  );

  // The carry lands in acc's MSB on every shift, so the extra carry bit of the
  // accumulator never needs its own flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            count  <= '0;
            busy   <= 1'b1;
`ifdef SEQ_MULT_ZERO_BYPASS_EN
            if ((a == '0) || (b == '0)) begin
              state   <= S_DONE;
              done    <= 1'b1;
              product <= '0;
            end else begin
              state <= S_RUN;
            end
`else
            state <= S_RUN;
`endif
          end
        end
        S_RUN: begin
          acc    <= {carry, sum[WIDTH-1:1]};
          mplier <= {sum[0], mplier[WIDTH-1:1]};
          count  <= count + 1'b1;
          // Product and done are registered on the final shift so both are
          // visible during the DONE cycle itself.
          if (count == CW'(WIDTH - 1)) begin
            state   <= S_DONE;
            done    <= 1'b1;
            product <= {carry, sum, mplier[WIDTH-1:1]};
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Self-checking bench for seq_mult_ctrl against an arithmetic a*b / latency model.
module tb_seq_mult_ctrl;
  import seq_mult_pkg::*;

  localparam int W = 4;
`ifdef SEQ_MULT_ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int n_cmp = 0;
  int n_err = 0;

  seq_mult_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int lat_of(input int x, input int y);
    return (BYPASS && (x == 0 || y == 0)) ? 1 : W + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // mode 0: quiet inputs after accept; 1: random start/a/b while busy;
  // 2: start pulses with a=7,b=7 in RUN cycles 2 and 4.
  task automatic do_mult(input logic [W-1:0] x, input logic [W-1:0] y, input int mode);
    int L;
    int first;
    int pulses;
    logic [2*W-1:0] exp;
    L      = lat_of(int'(x), int'(y));
    first  = -1;
    pulses = 0;
    exp    = (2*W)'(x) * (2*W)'(y);
    a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= W + 3; k++) begin
      if (k > 1) tick();
      chk("busy", 32'(busy), 32'(k <= L));
      if (done) begin
        pulses++;
        if (first < 0) first = k;
        chk("product_at_done", 32'(product), 32'(exp));
      end
      if (k <= L && mode == 1) begin
        start = 1'($urandom_range(0, 1));
        a     = W'($urandom);
        b     = W'($urandom);
      end else if (k <= L && mode == 2) begin
        start = (k == 2 || k == 4);
        a     = 4'd7;
        b     = 4'd7;
      end else begin
        start = 1'b0;
      end
    end
    chk("done_latency", 32'(first), 32'(L));
    chk("done_pulses", 32'(pulses), 32'd1);
    chk("product_held", 32'(product), 32'(exp));
  endtask

  initial begin
    int L1;
    int L2;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    tick();
    tick();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_product", 32'(product), 32'd0);
    rst = 1'b0;
    tick();

    do_mult(4'd13, 4'd11, 0);
    chk("t1_product", 32'(product), 32'h8F);
    do_mult(4'd15, 4'd15, 0);
    chk("t2_product", 32'(product), 32'hE1);
    do_mult(4'd0, 4'd9, 0);
    do_mult(4'd3, 4'd5, 2);
    chk("t4_product", 32'(product), 32'h0F);

    // reset in RUN cycle 2
    a = 4'd9; b = 4'd9; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_product", 32'(product), 32'd0);
    for (int k = 0; k < W + 2; k++) begin
      tick();
      chk("rst_mid_no_done", 32'(done), 32'd0);
    end

    do_mult(4'd6, 4'd7, 0);
    // reset and start in the same cycle: reset wins
    a = 4'd5; b = 4'd5; start = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", 32'(busy), 32'd0);
    chk("rst_start_product", 32'(product), 32'd0);
    for (int k = 0; k < W + 2; k++) begin
      tick();
      chk("rst_start_no_done", 32'(done), 32'd0);
    end

    // back-to-back with start held high
    L1 = lat_of(2, 3);
    L2 = lat_of(4, 4);
    a = 4'd2; b = 4'd3; start = 1'b1;
    tick();
    for (int k = 1; k <= L1 + L2 + 4; k++) begin
      if (k > 1) tick();
      chk("b2b_done", 32'(done), 32'(k == L1 || k == L1 + 1 + L2));
      chk("b2b_busy", 32'(busy), 32'((k <= L1) || (k >= L1 + 2 && k <= L1 + 1 + L2)));
      if (k == L1) chk("b2b_product1", 32'(product), 32'd6);
      if (k == L1 + 1 + L2) chk("b2b_product2", 32'(product), 32'd16);
      if (k == L1) begin a = 4'd4; b = 4'd4; end
      if (k == L1 + 1 + L2) start = 1'b0;
    end

    for (int i = 0; i < 256; i++) begin
      do_mult(W'(i / 16), W'(i % 16), 0);
    end
    for (int i = 0; i < 40; i++) begin
      do_mult(W'($urandom), W'($urandom), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
